sha256_padder: RTL and testbench
================================

Name: sha256_padder

Overview:
- Message front end for the sha256 core. Accepts a message as a stream of 32-bit big-endian words and emits complete 512-bit blocks on a valid/ready interface that connects directly to the core's block input.
- Applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit bit-length field. Produces one or two final blocks as required.
- Flags the first and last block of each message, so the PBKDF2 controller knows when to reload H and when to take the digest.

Parameters:
- LEN_W, 32: byte-counter width. The bit length (bytes×8) is zero-extended to the 64-bit length field. The counter wraps modulo 2^LEN_W, silently.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_data  in  32  message word. First message byte is in [31:24].
- in_bytes  in  3  valid bytes in the word, 1..4 (left-justified). Must be 4 unless in_last. 0 is legal only with in_last (empty tail).
- in_last  in  1  final word of the message.
- in_ready  out  1  word accepted when in_valid && in_ready.
- out_valid  out  1  block valid.
- out_block  out  512  padded block. Word 0 is [511:480]; byte 0 is [511:504].
- out_first  out  1  block is the first of its message.
- out_last  out  1  block is the final block of its message.
- out_ready  in  1  block consumed when out_valid && out_ready.

Behaviour:
- Reset (async, rst_ni=0):
  - in_ready=0, out_valid=0, out_first=0, out_last=0, out_block=0.
  - Buffer, word index and byte counter cleared; state FILL.
  - in_ready rises on the first clock after release.
- Reset mid-message or mid-emission aborts immediately. Nothing is retained.
- State FILL:
  - in_ready=1. Each accepted word is written to buffer word widx; widx increments; byte counter += in_bytes.
  - Accepting word 15 without in_last → EMIT_DATA. out_valid=1 on the next cycle. out_last=0.
  - Accepting a word with in_last → PAD.
- State PAD (1 cycle, in_ready=0):
  - Place 0x80 at byte position p = total bytes mod 64 within the block (bytes are counted after the last word). Zero all bytes after it.
  - If p ≤ 55: write the 64-bit length into words 14-15 → EMIT_FINAL.
  - Otherwise → EMIT_SPILL.
  - If the block is exactly full (p = 64 wraps to 0 of the next block): emit the current block as EMIT_SPILL with no 0x80. The extra block then starts with 0x80000000.
- State EMIT_DATA / EMIT_SPILL:
  - out_valid=1, out_last=0.
  - On handshake: EMIT_DATA → FILL, with widx=0 and the buffer cleared; EMIT_SPILL → EXTRA.
- State EXTRA (1 cycle):
  - Build a block of zeros plus the length in words 14-15. Word 0 is 0x80000000 if 0x80 was not yet placed.
  - → EMIT_FINAL.
- State EMIT_FINAL:
  - out_valid=1, out_last=1.
  - On handshake → FILL. Byte counter cleared; the next block sets out_first.
- Output hold rules:
  - out_block, out_first and out_last are stable while out_valid && !out_ready.
  - in_ready=0 in every state except FILL.
- out_first=1 on the first block emitted after reset or after an EMIT_FINAL handshake.
- Latency:
  - Last accepted word of a non-final block at cycle T → out_valid at T+1.
  - in_last accepted at T → first padded block at T+2.
  - Spill block at (handshake cycle)+2.
- Throughput:
  - One word per cycle in FILL, so 16 cycles per block minimum plus 1 emit cycle.
  - No input is accepted during emission.
- Length field: bits = {counter, 3'b000}, zero-extended to 64 bits, big-endian in words 14 (high) and 15 (low).
- in_valid with in_bytes=0 and !in_last: the word is ignored (not written, counter unchanged). in_ready behaviour is unaffected.

Optional Feature:
- SHA256_PAD_LEN_OFFSET_EN
- Defined:
  - Adds input port len_offset [LEN_W-1:0]. It is sampled on the first accepted word of each message and added to the byte counter for the length field only.
  - This supports HMAC/PBKDF2 inner and outer hashes where a 64-byte key block was compressed separately.
  - out_first is suppressed (held 0) when the sampled offset is nonzero.
- Undefined: no port; offset is zero.

Test Plan:
- "abc": one word 0x61626300, in_bytes=3, in_last → single block 0x61626380, 13 zero words, 0x00000000, 0x00000018. out_first=1, out_last=1, out_valid at T+2.
- Empty message: in_last, in_bytes=0 → block 0x80000000, zeros, length 0. first=last=1.
- 56 bytes (14 full words, last flagged) → block 1: data + 0x80000000 at word 14, word 15=0, last=0. Block 2: zeros, words 14/15 = 0x00000000, 0x000001C0. last=1.
- 64 bytes (16 full words, last flagged) → block 1 pure data, first=1, last=0. Block 2: 0x80000000, zeros, length 0x00000200, last=1.
- Backpressure: out_ready=0 for 10 cycles during emission → block held bit-stable, in_ready=0 throughout. Accept on release; in_ready=1 on the next cycle.
- rst_ni pulsed low while in EMIT_SPILL → outputs 0 immediately. A following "abc" message yields the correct single block with out_first=1.

Source files
------------

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks and appends 0x80/zeros/length.
// Optional build macro SHA256_PAD_LEN_OFFSET_EN adds a len_offset input for HMAC/PBKDF2 use.
module sha256_padder #(
    parameter int unsigned LEN_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic [2:0]       in_bytes,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [511:0]     out_block,
    output logic             out_first,
    output logic             out_last,
    input  logic             out_ready
`ifdef SHA256_PAD_LEN_OFFSET_EN
    ,
    input  logic [LEN_W-1:0] len_offset
`endif
);

    typedef enum logic [2:0] {
        StFill,
        StPad,
        StEmitData,
        StEmitSpill,
        StExtra,
        StEmitFinal
    } state_e;

    state_e             state_q, state_d;
    logic [511:0]       buf_q, buf_d;
    logic [3:0]         widx_q, widx_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               first_q, first_d;
    logic               placed_q, placed_d;
    logic               full_q, full_d;
    logic               init_q;
    logic [LEN_W-1:0]   off;
    logic [LEN_W-1:0]   len_sum;
    logic [63:0]        len_bits;
    logic [5:0]         pad_pos;
    logic [511:0]       pad_blk;
    logic               accept;

`ifdef SHA256_PAD_LEN_OFFSET_EN
    logic [LEN_W-1:0]   off_q, off_d;
    logic               start_q, start_d;
    assign off = off_q;
`else
    assign off = '0;
`endif

    assign len_sum  = cnt_q + off;
    assign len_bits = 64'({len_sum, 3'b000});
    assign pad_pos  = cnt_q[5:0];

    assign in_ready  = init_q && (state_q == StFill);
    assign out_valid = (state_q == StEmitData) || (state_q == StEmitSpill) ||
                       (state_q == StEmitFinal);
    assign out_last  = (state_q == StEmitFinal);
    assign out_block = buf_q;
`ifdef SHA256_PAD_LEN_OFFSET_EN
    assign out_first = out_valid && first_q && (off_q == '0);
`else
    assign out_first = out_valid && first_q;
`endif

    // Zero-length words without in_last are consumed but have no effect.
    assign accept = in_valid && in_ready && !((in_bytes == 3'd0) && !in_last);

    // Marker byte at pad_pos, everything after it cleared; an exactly full block is left alone.
    always_comb begin
        pad_blk = buf_q;
        if (!full_q) begin
            for (int i = 0; i < 64; i++) begin
                if (i == int'(pad_pos)) begin
                    pad_blk[511 - 8*i -: 8] = 8'h80;
                end else if (i > int'(pad_pos)) begin
                    pad_blk[511 - 8*i -: 8] = 8'h00;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        widx_d   = widx_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        placed_d = placed_q;
        full_d   = full_q;
`ifdef SHA256_PAD_LEN_OFFSET_EN
        off_d    = off_q;
        start_d  = start_q;
`endif
        unique case (state_q)
            StFill: begin
                if (accept) begin
                    buf_d[511 - 32*widx_q -: 32] = in_data;
                    widx_d = widx_q + 4'd1;
                    cnt_d  = cnt_q + LEN_W'(in_bytes);
`ifdef SHA256_PAD_LEN_OFFSET_EN
                    if (start_q) begin
                        off_d   = len_offset;
                        start_d = 1'b0;
                    end
`endif
                    if (in_last) begin
                        full_d  = (widx_q == 4'd15) && (in_bytes == 3'd4);
                        state_d = StPad;
                    end else if (widx_q == 4'd15) begin
                        state_d = StEmitData;
                    end
                end
            end
            StPad: begin
                if (full_q) begin
                    placed_d = 1'b0;
                    state_d  = StEmitSpill;
                end else if (pad_pos <= 6'd55) begin
                    buf_d    = {pad_blk[511:64], len_bits};
                    placed_d = 1'b1;
                    state_d  = StEmitFinal;
                end else begin
                    buf_d    = pad_blk;
                    placed_d = 1'b1;
                    state_d  = StEmitSpill;
                end
            end
            StEmitData: begin
                if (out_ready) begin
                    buf_d   = '0;
                    widx_d  = 4'd0;
                    first_d = 1'b0;
                    state_d = StFill;
                end
            end
            StEmitSpill: begin
                if (out_ready) begin
                    first_d = 1'b0;
                    state_d = StExtra;
                end
            end
            StExtra: begin
                buf_d = '0;
                if (!placed_q) begin
                    buf_d[511:480] = 32'h8000_0000;
                end
                buf_d[63:0] = len_bits;
                state_d     = StEmitFinal;
            end
            StEmitFinal: begin
                if (out_ready) begin
                    buf_d    = '0;
                    widx_d   = 4'd0;
                    cnt_d    = '0;
                    first_d  = 1'b1;
                    placed_d = 1'b0;
                    full_d   = 1'b0;
`ifdef SHA256_PAD_LEN_OFFSET_EN
                    start_d  = 1'b1;
`endif
                    state_d  = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StFill;
            buf_q    <= '0;
            widx_q   <= 4'd0;
            cnt_q    <= '0;
            first_q  <= 1'b1;
            placed_q <= 1'b0;
            full_q   <= 1'b0;
            init_q   <= 1'b0;
`ifdef SHA256_PAD_LEN_OFFSET_EN
            off_q    <= '0;
            start_q  <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            widx_q   <= widx_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            placed_q <= placed_d;
            full_q   <= full_d;
            init_q   <= 1'b1;
`ifdef SHA256_PAD_LEN_OFFSET_EN
            off_q    <= off_d;
            start_q  <= start_d;
`endif
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: short, empty, spill, exact-fill, multi-block and reset cases.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [31:0]  in_data = '0;
    logic [2:0]   in_bytes = '0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid, out_first, out_last;
    logic [511:0] out_block;
    int           total = 0;
    int           bad = 0;
    logic [511:0] exp_blk, held;
    int           n;

    always #5 clk = ~clk;

    sha256_padder #(.LEN_W(32)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_bytes  (in_bytes),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_block (out_block),
        .out_first (out_first),
        .out_last  (out_last),
        .out_ready (out_ready)
`ifdef SHA256_PAD_LEN_OFFSET_EN
        ,
        .len_offset(32'd0)
`endif
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [2:0] b, input logic l);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_bytes = b;
        in_last  = l;
        while (!in_ready && k < 64) begin
            step();
            k++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $error("FAIL send_timeout: observed in_ready=0 expected 1");
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Cycles waited (sample points) until out_valid; 64 means timeout.
    task automatic wait_out(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 64) begin
            step();
            cnt++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset
        #3 rst_n = 1'b0;
        #20;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_block", out_block, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rel_in_ready_low", in_ready, 0);
        step();
        chk("rel_in_ready_high", in_ready, 1);

        // "abc"
        send(32'h6162_6300, 3'd3, 1'b1);
        wait_out(n);
        chk("abc_latency", n, 1);
        exp_blk = '0;
        exp_blk[511:480] = 32'h6162_6380;
        exp_blk[31:0] = 32'h0000_0018;
        chk("abc_block", out_block, exp_blk);
        chk("abc_first", out_first, 1);
        chk("abc_last", out_last, 1);
        handshake();
        chk("abc_in_ready_after", in_ready, 1);

        // Empty message
        send(32'h0, 3'd0, 1'b1);
        wait_out(n);
        exp_blk = '0;
        exp_blk[511:480] = 32'h8000_0000;
        chk("empty_block", out_block, exp_blk);
        chk("empty_first", out_first, 1);
        chk("empty_last", out_last, 1);
        handshake();

        // 56 bytes: padding spills into a second block
        for (int i = 0; i < 14; i++) send(32'hA500_0000 + i, 3'd4, i == 13);
        wait_out(n);
        chk("b56_latency", n, 1);
        exp_blk = '0;
        for (int i = 0; i < 14; i++) exp_blk[511 - 32*i -: 32] = 32'hA500_0000 + i;
        exp_blk[63:32] = 32'h8000_0000;
        chk("b56_blk1", out_block, exp_blk);
        chk("b56_blk1_first", out_first, 1);
        chk("b56_blk1_last", out_last, 0);
        handshake();
        wait_out(n);
        chk("b56_spill_latency", n, 1);
        exp_blk = '0;
        exp_blk[31:0] = 32'h0000_01C0;
        chk("b56_blk2", out_block, exp_blk);
        chk("b56_blk2_first", out_first, 0);
        chk("b56_blk2_last", out_last, 1);
        handshake();

        // 64 bytes with backpressure on the data block
        for (int i = 0; i < 16; i++) send(32'hC300_0000 + i, 3'd4, i == 15);
        wait_out(n);
        exp_blk = '0;
        for (int i = 0; i < 16; i++) exp_blk[511 - 32*i -: 32] = 32'hC300_0000 + i;
        chk("b64_blk1", out_block, exp_blk);
        chk("b64_blk1_first", out_first, 1);
        chk("b64_blk1_last", out_last, 0);
        held = out_block;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("bp_hold_block", out_block, held);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        handshake();
        wait_out(n);
        exp_blk = '0;
        exp_blk[511:480] = 32'h8000_0000;
        exp_blk[31:0] = 32'h0000_0200;
        chk("b64_blk2", out_block, exp_blk);
        chk("b64_blk2_first", out_first, 0);
        chk("b64_blk2_last", out_last, 1);
        handshake();
        chk("b64_in_ready_after", in_ready, 1);

        // 66 bytes across a data block, with an ignored empty word mid-stream
        for (int i = 0; i < 16; i++) begin
            send(32'hB000_0000 + i, 3'd4, 1'b0);
            if (i == 3) send(32'hDEAD_BEEF, 3'd0, 1'b0);
        end
        wait_out(n);
        chk("m66_data_latency", n, 0);
        exp_blk = '0;
        for (int i = 0; i < 16; i++) exp_blk[511 - 32*i -: 32] = 32'hB000_0000 + i;
        chk("m66_blk1", out_block, exp_blk);
        chk("m66_blk1_first", out_first, 1);
        chk("m66_blk1_last", out_last, 0);
        handshake();
        chk("m66_in_ready_refill", in_ready, 1);
        send(32'h1122_FFFF, 3'd2, 1'b1);
        wait_out(n);
        exp_blk = '0;
        exp_blk[511:480] = 32'h1122_8000;
        exp_blk[31:0] = 32'h0000_0210;
        chk("m66_blk2", out_block, exp_blk);
        chk("m66_blk2_first", out_first, 0);
        chk("m66_blk2_last", out_last, 1);
        handshake();

        // Reset while the spill block is being offered
        for (int i = 0; i < 14; i++) send(32'hE700_0000 + i, 3'd4, i == 13);
        wait_out(n);
        chk("rs_spill_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rs_out_valid", out_valid, 0);
        chk("rs_out_block", out_block, 0);
        chk("rs_out_last", out_last, 0);
        chk("rs_in_ready", in_ready, 0);
        step();
        rst_n = 1'b1;
        step();
        send(32'h6162_6300, 3'd3, 1'b1);
        wait_out(n);
        exp_blk = '0;
        exp_blk[511:480] = 32'h6162_6380;
        exp_blk[31:0] = 32'h0000_0018;
        chk("rs_abc_block", out_block, exp_blk);
        chk("rs_abc_first", out_first, 1);
        chk("rs_abc_last", out_last, 1);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
